// File: rtl/ascon_pack.sv
// Shared types and helpers for the Ascon permutation datapath.
package ascon_pack;

  localparam int NB_ROUNDS_MAX = 12;

  // Word 0 is x0, word 4 is x4.
  typedef logic [4:0][63:0] type_state;

  typedef enum logic [1:0] {IDLE, RUN, DONE} type_fsm_pc;

  // Round r (0..11) constant: high nibble counts down from F, low nibble is r.
  function automatic logic [7:0] round_constant(input logic [3:0] r);
    return {4'hF - r, r};
  endfunction

endpackage

// File: rtl/pc_round_ctrl_pc.sv
// Constant-addition layer: XORs the round constant into the low byte of x2.
module pc_round_ctrl_pc
  import ascon_pack::*;
(
  input  type_state  state_i,
  input  logic [3:0] round_i,
  output type_state  state_o
);

  always_comb begin
    state_o          = state_i;
    state_o[2][7:0]  = state_i[2][7:0] ^ round_constant(round_i);
  end

endmodule

// File: rtl/pc_round_ctrl.sv
// Iterative Ascon round controller: state register, round counter and start/done
// handshake around an externally supplied substitution + linear layer.
module pc_round_ctrl
  import ascon_pack::*;
#(
  parameter int unsigned ROUNDS_A = 12,
  parameter int unsigned ROUNDS_B = 6
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       mode_i,
  input  type_state  state_i,
  input  type_state  feedback_i,
  output type_state  pc_o,
  output type_state  state_o,
  output logic [3:0] round_o,
  output logic       busy_o,
  output logic       done_o
);

  // Shorter permutations start late so every run ends on the last constant.
  localparam logic [3:0] FIRST_A    = 4'(NB_ROUNDS_MAX - ROUNDS_A);
  localparam logic [3:0] FIRST_B    = 4'(NB_ROUNDS_MAX - ROUNDS_B);
  localparam logic [3:0] LAST_ROUND = 4'(NB_ROUNDS_MAX - 1);

  type_fsm_pc fsm_q, fsm_d;
  type_state  state_q, state_d;
  logic [3:0] round_q, round_d;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      round_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    round_d = round_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (start_i) begin
          state_d = state_i;
          round_d = mode_i ? FIRST_B : FIRST_A;
          fsm_d   = RUN;
        end
      end
      RUN: begin
        busy_o  = 1'b1;
        state_d = feedback_i;
        if (round_q == LAST_ROUND) fsm_d   = DONE;
        else                       round_d = round_q + 4'd1;
      end
      DONE: begin
        done_o = 1'b1;
        fsm_d  = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  pc_round_ctrl_pc u_pc (
    .state_i (state_q),
    .round_i (round_q),
    .state_o (pc_o)
  );

  assign state_o = state_q;
  assign round_o = round_q;

endmodule

// File: tb/tb_pc_round_ctrl.sv
// Bench for pc_round_ctrl: loopback, constant, ignored-start, reset and full
// Ascon permutation runs against a round-by-round reference.
module tb_pc_round_ctrl;
  import ascon_pack::*;

  localparam int RA = 12;
  localparam int RB = 6;
  localparam logic [63:0] IV = 64'h80400C0600000000;

  logic       clock_i = 1'b0;
  logic       reset_i = 1'b0;
  logic       start_i = 1'b0;
  logic       mode_i  = 1'b0;
  type_state  state_i = '0;
  type_state  feedback_i;
  type_state  pc_o, state_o;
  logic [3:0] round_o;
  logic       busy_o, done_o;

  logic fb_perm = 1'b0;
  int   checks = 0;
  int   failures = 0;

  pc_round_ctrl #(.ROUNDS_A(RA), .ROUNDS_B(RB)) dut (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .start_i    (start_i),
    .mode_i     (mode_i),
    .state_i    (state_i),
    .feedback_i (feedback_i),
    .pc_o       (pc_o),
    .state_o    (state_o),
    .round_o    (round_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  always #5 clock_i = ~clock_i;

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Ascon substitution + linear layer, as in the C reference.
  function automatic type_state ps_pl(input type_state s);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    type_state o;
    x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
    x0 ^= x4; x4 ^= x3; x2 ^= x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
    x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
    o[0] = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    o[1] = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    o[2] = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
    o[3] = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    o[4] = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    return o;
  endfunction

  function automatic type_state add_const(input type_state s, input int r);
    type_state o;
    o = s;
    o[2][7:0] = o[2][7:0] ^ 8'(((15 - r) << 4) | r);
    return o;
  endfunction

  // Reference: apply rounds 12-n..11, with or without the real round function.
  function automatic type_state model(input type_state s, input int n, input logic perm);
    type_state x;
    x = s;
    for (int r = 12 - n; r < 12; r++) begin
      x = add_const(x, r);
      if (perm) x = ps_pl(x);
    end
    return x;
  endfunction

  always_comb feedback_i = fb_perm ? ps_pl(pc_o) : pc_o;

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock_i); #1;
  endtask

  function automatic type_state rnd_state();
    type_state s;
    for (int w = 0; w < 5; w++) s[w] = {$urandom, $urandom};
    return s;
  endfunction

  task automatic run_perm(input type_state s, input logic m, input logic ign);
    int n, cyc;
    type_state exp, res;
    n = m ? RB : RA;
    exp = model(s, n, fb_perm);
    start_i = 1'b1; mode_i = m; state_i = s;
    step();
    start_i = 1'b0; mode_i = ~m; state_i = rnd_state();
    chk("first_pc", pc_o, add_const(s, 12 - n));
    cyc = 0;
    while (!done_o && cyc < 20) begin
      chk("busy", {319'd0, busy_o}, 320'd1);
      chk("round", {316'd0, round_o}, 320'(12 - n + cyc));
      if (ign && cyc == 3) begin start_i = 1'b1; state_i = rnd_state(); end
      else start_i = 1'b0;
      step();
      cyc++;
    end
    start_i = 1'b0;
    chk("latency", 320'(cyc), 320'(n));
    chk("done_busy", {318'd0, done_o, busy_o}, 320'b10);
    chk("result", state_o, exp);
    res = state_o;
    if (ign) begin start_i = 1'b1; state_i = rnd_state(); mode_i = 1'b1; end
    step();
    start_i = 1'b0;
    chk("idle_flags", {318'd0, done_o, busy_o}, 320'b00);
    chk("hold", state_o, res);
    step();
    chk("still_idle", {318'd0, done_o, busy_o}, 320'b00);
  endtask

  initial begin
    type_state s;
    reset_i = 1'b1;
    #12;
    chk("rst_state", state_o, '0);
    chk("rst_flags", {313'd0, round_o, done_o, busy_o}, 320'd0);
    reset_i = 1'b0;
    step();

    fb_perm = 1'b0;
    run_perm({5{64'h0123456789ABCDEF}}, 1'b0, 1'b0);
    chk("loop12_word", state_o, {5{64'h0123456789ABCDEF}});
    run_perm('0, 1'b1, 1'b0);
    chk("loop6_word2", state_o, {64'd0, 64'd0, 64'h11, 64'd0, 64'd0});
    run_perm('0, 1'b0, 1'b0);
    run_perm(rnd_state(), 1'b0, 1'b1);
    run_perm(rnd_state(), 1'b1, 1'b1);

    // Reset asserted between edges during RUN clears outputs at once.
    start_i = 1'b1; mode_i = 1'b0; state_i = rnd_state();
    step();
    start_i = 1'b0;
    step(); step();
    #3 reset_i = 1'b1;
    #1;
    chk("midrst_state", state_o, '0);
    chk("midrst_flags", {313'd0, round_o, done_o, busy_o}, 320'd0);
    #1 reset_i = 1'b0;
    step();
    chk("post_rst_idle", {318'd0, done_o, busy_o}, 320'b00);

    fb_perm = 1'b1;
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 100; i++) begin
        s = rnd_state();
        s[0] = IV;
        run_perm(s, m[0], (i % 17) == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
